// File: rtl/write_skid_buffer.sv
// Write-side front end of the async FIFO: 2-entry skid buffer ahead of
// full_gen, with a saturating counter of cycles stalled on a full FIFO.
module write_skid_buffer #(
  parameter int WIDTH      = 8,
  parameter int STALL_BITS = 16
) (
  input  logic                  write_clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  input  logic                  full_flag,
  output logic                  valid_write,
  output logic [WIDTH-1:0]      write_data,
  output logic                  commit,
  output logic [STALL_BITS-1:0] stall_count,
  output logic [1:0]            occupancy
);

  // State encoding equals the number of words held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      head_q, head_d;
  logic [WIDTH-1:0]      skid_q, skid_d;
  logic                  ready_q, ready_d;
  logic [STALL_BITS-1:0] stall_q, stall_d;

  logic head_valid;
  logic accept;
  logic commit_w;

  assign head_valid = (state_q != EMPTY);
  assign accept     = in_valid && ready_q;
  assign commit_w   = head_valid && !full_flag;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && commit_w) begin
          head_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (commit_w) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (commit_w) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_comb begin
    ready_d = (state_d != TWO);
    stall_d = stall_q;
    if (head_valid && full_flag && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge write_clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      stall_q <= stall_d;
    end
  end

  assign in_ready    = ready_q;
  assign valid_write = head_valid;
  assign write_data  = head_q;
  assign commit      = commit_w;
  assign stall_count = stall_q;
  assign occupancy   = state_q;

endmodule

// File: tb/tb_write_skid_buffer.sv
// Bench for write_skid_buffer: queue model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_write_skid_buffer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       full_flag;

  logic        in_ready, valid_write, commit;
  logic [7:0]  write_data;
  logic [15:0] stall_count;
  logic [1:0]  occupancy;

  logic       in_ready_s, valid_write_s, commit_s;
  logic [7:0] write_data_s;
  logic [3:0] stall_count_s;
  logic [1:0] occupancy_s;

  write_skid_buffer #(.WIDTH(8), .STALL_BITS(16)) dut (
    .write_clock (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .full_flag   (full_flag),
    .valid_write (valid_write),
    .write_data  (write_data),
    .commit      (commit),
    .stall_count (stall_count),
    .occupancy   (occupancy)
  );

  write_skid_buffer #(.WIDTH(8), .STALL_BITS(4)) dut_s (
    .write_clock (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready_s),
    .full_flag   (full_flag),
    .valid_write (valid_write_s),
    .write_data  (write_data_s),
    .commit      (commit_s),
    .stall_count (stall_count_s),
    .occupancy   (occupancy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: a plain FIFO of held words plus an unbounded stall tally.
  logic [7:0] mq[$];
  int         mstall = 0;
  int         cyc = 0;
  logic [7:0] log_d[$];
  int         log_c[$];
  int         acc_c[$];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", n, a, e, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic run_model();
    int  n;
    bit  acc, com;
    forever begin
      @(negedge clk);
      if (reset) begin
        mq.delete();
        mstall = 0;
      end
      n = mq.size();
      chk("valid_write", 32'(valid_write), 32'(n > 0));
      chk("occupancy", 32'(occupancy), 32'(n));
      chk("in_ready", 32'(in_ready), 32'(n < 2));
      chk("commit", 32'(commit), 32'((n > 0) && !full_flag));
      if (n > 0) chk("write_data", 32'(write_data), 32'(mq[0]));
      chk("stall16", 32'(stall_count), 32'(sat(mstall, 65535)));
      chk("stall4", 32'(stall_count_s), 32'(sat(mstall, 15)));
      chk("occ_s", 32'(occupancy_s), 32'(n));
      @(posedge clk);
      cyc++;
      if (reset) begin
        mq.delete();
        mstall = 0;
      end else begin
        n   = mq.size();
        acc = in_valid && (n < 2);
        com = (n > 0) && !full_flag;
        if (n > 0 && full_flag) mstall++;
        if (com) begin
          log_d.push_back(mq[0]);
          log_c.push_back(cyc);
          void'(mq.pop_front());
        end
        if (acc) begin
          mq.push_back(in_data);
          acc_c.push_back(cyc);
        end
      end
    end
  endtask

  // Presents w until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] w);
    bit r;
    bit done;
    in_valid = 1'b1;
    in_data  = w;
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) done = 1;
    end
    if (!done) chk("send_timeout", 32'(w), 32'hFFFF_FFFF);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base, abase;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    full_flag = 1'b0;
    fork
      run_model();
    join_none
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 32'(valid_write), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_stall", 32'(stall_count), 32'h0);

    // Streaming 0x01..0x10
    base  = log_d.size();
    abase = acc_c.size();
    for (int i = 1; i <= 16; i++) begin
      send(8'(i));
      chk("stream_ready", 32'(in_ready), 32'h1);
    end
    idle(3);
    chk("stream_cnt", 32'(log_d.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < log_d.size()) begin
        chk("stream_data", 32'(log_d[base+i]), 32'(i + 1));
        chk("stream_cyc", 32'(log_c[base+i]), 32'(acc_c[abase] + 1 + i));
      end
    end

    // Full stall with skid landing
    base = log_d.size();
    send(8'hA0);
    full_flag = 1'b1;
    send(8'hA1);
    in_data = 8'hA2;
    chk("stall_ready", 32'(in_ready), 32'h0);
    chk("stall_occ", 32'(occupancy), 32'h2);
    chk("stall_head", 32'(write_data), 32'hA0);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("stall_hold", 32'(write_data), 32'hA0);
      chk("stall_rdy0", 32'(in_ready), 32'h0);
    end
    chk("stall_cnt5", 32'(stall_count), 32'd5);
    full_flag = 1'b0;
    send(8'hA2);
    idle(3);
    chk("full_cnt", 32'(log_d.size() - base), 32'd3);
    if (log_d.size() >= base + 3) begin
      chk("full_d0", 32'(log_d[base]), 32'hA0);
      chk("full_d1", 32'(log_d[base+1]), 32'hA1);
      chk("full_d2", 32'(log_d[base+2]), 32'hA2);
    end

    // Accept and commit together at occupancy 1
    base  = log_d.size();
    abase = acc_c.size();
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h30 + i));
      chk("sim_occ1", 32'(occupancy), 32'h1);
      chk("sim_head", 32'(write_data), 32'(8'h30 + i));
    end
    idle(2);
    chk("sim_cnt", 32'(log_d.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < log_d.size()) begin
        chk("sim_data", 32'(log_d[base+i]), 32'(8'h30 + i));
        chk("sim_cyc", 32'(log_c[base+i]), 32'(acc_c[abase] + 1 + i));
      end
    end

    // Saturation on the 4-bit counter
    full_flag = 1'b1;
    send(8'h55);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("sat_15", 32'(stall_count_s), 32'd15);
    chk("sat_head", 32'(write_data), 32'h55);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", 32'(stall_count_s), 32'd15);
    full_flag = 1'b0;
    idle(3);

    // Reset mid-operation with two words held
    base = log_d.size();
    full_flag = 1'b1;
    send(8'hB0);
    send(8'hB1);
    in_valid = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_write), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h1);
    chk("arst_occ", 32'(occupancy), 32'h0);
    chk("arst_stall", 32'(stall_count), 32'h0);
    chk("arst_commit", 32'(commit), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    full_flag = 1'b0;
    abase = acc_c.size();
    send(8'hC0);
    idle(3);
    chk("post_cnt", 32'(log_d.size() - base), 32'd1);
    if (log_d.size() > base) begin
      chk("post_data", 32'(log_d[base]), 32'hC0);
      chk("post_cyc", 32'(log_c[base]), 32'(acc_c[abase] + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
